// File: rtl/move_executor.sv
// move_executor: applies 32-bit move words to the square array (clear origin, then load destination).
// Defining MOVE_UNDO_EN adds an undo stack so unmake_req can reverse completed moves.
module move_executor #(
    parameter int         STACK_DEPTH = 16,
    parameter logic [3:0] KNIGHT_TYPE = 4'd2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] move_in,
    input  logic        move_in_valid,
    output logic        move_in_ready,
    input  logic        unmake_req,
    output logic [5:0]  board_sel,
    output logic [5:0]  board_piece,
    output logic        board_enable,
    output logic        board_clear,
    output logic        move_done,
    output logic [5:0]  captured_piece,
    output logic        err,
    output logic [4:0]  stack_count
);
    localparam logic [31:0] RSVD_MASK = 32'hC0C0_C0C0;

    typedef enum logic [2:0] {IDLE, CLR_SRC, LD_DST, DONE, U_LD_SRC, U_RST_DST} state_t;
    state_t state, state_nx;

    logic [31:0] word_q;
    logic [31:0] pop_word;
    logic        undo_q;
    logic        accept, empty_word, bad_word;
    logic        stack_full, unmake_block, unmake_go, unmake_err;

    function automatic logic [5:0] mover_code(input logic [31:0] w);
        return {w[13], 1'b0, (w[8] ? KNIGHT_TYPE : w[12:9])};
    endfunction

    assign empty_word = (move_in == 32'h0);
    assign bad_word   = !empty_word &&
                        (((move_in & RSVD_MASK) != 32'h0) || (move_in[5:0] == move_in[21:16]));
    assign move_in_ready = (state == IDLE) & ~unmake_block & ~stack_full & ~reset;
    assign accept        = move_in_valid & move_in_ready;

`ifdef MOVE_UNDO_EN
    localparam int AW = $clog2(STACK_DEPTH);
    logic [31:0] stack_mem [STACK_DEPTH];
    logic [4:0]  count_q;

    assign stack_full   = (count_q == 5'(STACK_DEPTH));
    assign unmake_block = unmake_req;
    assign unmake_go    = (state == IDLE) & unmake_req & (count_q != 5'd0);
    assign unmake_err   = (state == IDLE) & unmake_req & (count_q == 5'd0);
    assign pop_word     = stack_mem[AW'(count_q - 5'd1)];
    assign stack_count  = count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count_q <= '0;
        else if (unmake_go)
            count_q <= count_q - 5'd1;
        else if (state == DONE && !undo_q)
            count_q <= count_q + 5'd1;
    end

    // Only forward moves are recorded; the push happens as the move completes.
    always_ff @(posedge clk) begin
        if (state == DONE && !undo_q)
            stack_mem[count_q[AW-1:0]] <= word_q;
    end
`else
    logic unused_undo;
    assign unused_undo  = unmake_req ^ (STACK_DEPTH == 0);
    assign stack_full   = 1'b0;
    assign unmake_block = 1'b0;
    assign unmake_go    = 1'b0;
    assign unmake_err   = 1'b0;
    assign pop_word     = '0;
    assign stack_count  = '0;
`endif

    always_ff @(posedge clk) begin
        if (unmake_go)
            word_q <= pop_word;
        else if (accept)
            word_q <= move_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            err            <= 1'b0;
            captured_piece <= '0;
            undo_q         <= 1'b0;
        end else begin
            state <= state_nx;
            err   <= (accept & bad_word) | unmake_err;
            if (state == LD_DST)
                captured_piece <= word_q[29:24];
            else if (state == U_RST_DST)
                captured_piece <= '0;
            if (unmake_go)
                undo_q <= 1'b1;
            else if (accept)
                undo_q <= 1'b0;
        end
    end

    always_comb begin
        state_nx     = state;
        board_sel    = '0;
        board_piece  = '0;
        board_enable = 1'b0;
        board_clear  = 1'b0;
        move_done    = 1'b0;
        unique case (state)
            IDLE: begin
                if (unmake_go)
                    state_nx = U_LD_SRC;
                else if (accept && !empty_word && !bad_word)
                    state_nx = CLR_SRC;
            end
            CLR_SRC: begin
                board_clear = 1'b1;
                board_sel   = word_q[5:0];
                state_nx    = LD_DST;
            end
            LD_DST: begin
                board_enable = 1'b1;
                board_sel    = word_q[21:16];
                board_piece  = mover_code(word_q);
                state_nx     = DONE;
            end
            DONE: begin
                move_done = 1'b1;
                state_nx  = IDLE;
            end
            U_LD_SRC: begin
                board_enable = 1'b1;
                board_sel    = word_q[5:0];
                board_piece  = mover_code(word_q);
                state_nx     = U_RST_DST;
            end
            // An empty capture field means the destination was vacant before the move.
            U_RST_DST: begin
                board_sel = word_q[21:16];
                if (word_q[29:24] != 6'h0) begin
                    board_enable = 1'b1;
                    board_piece  = word_q[29:24];
                end else begin
                    board_clear = 1'b1;
                end
                state_nx = DONE;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_move_executor.sv
// Scoreboard bench for move_executor: stimulus queues expected board/done/err events,
// a negedge monitor pops and compares every event the DUT presents.
module tb_move_executor;
    localparam logic [3:0] KT = 4'd2;
    localparam logic [3:0] K_CLR = 4'b0001, K_LD = 4'b0010, K_DONE = 4'b0100, K_ERR = 4'b1000;
    localparam logic [31:0] W1 = 32'h2815_0408;
    localparam logic [31:0] W2 = 32'h003F_2101;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] move_in = '0;
    logic        move_in_valid = 1'b0;
    logic        unmake_req = 1'b0;
    logic        move_in_ready;
    logic [5:0]  board_sel, board_piece, captured_piece;
    logic        board_enable, board_clear, move_done, err;
    logic [4:0]  stack_count;

    move_executor #(.STACK_DEPTH(16), .KNIGHT_TYPE(KT)) dut (
        .clk(clk), .reset(reset), .move_in(move_in), .move_in_valid(move_in_valid),
        .move_in_ready(move_in_ready), .unmake_req(unmake_req), .board_sel(board_sel),
        .board_piece(board_piece), .board_enable(board_enable), .board_clear(board_clear),
        .move_done(move_done), .captured_piece(captured_piece), .err(err),
        .stack_count(stack_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int         cyc;
        logic [3:0] kind;
        logic [5:0] sel;
        logic [5:0] piece;
        logic [5:0] cap;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_got, mon_exp;
    int  n_cmp = 0;
    int  n_bad = 0;

    always @(negedge clk) begin
        if (!reset && (board_enable || board_clear || move_done || err)) begin
            mon_got.cyc   = cyc;
            mon_got.kind  = {err, move_done, board_enable, board_clear};
            mon_got.sel   = board_sel;
            mon_got.piece = board_piece;
            mon_got.cap   = move_done ? captured_piece : 6'h0;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event: got cyc=%0d kind=%b sel=%0d piece=%h cap=%h, required no event",
                         mon_got.cyc, mon_got.kind, mon_got.sel, mon_got.piece, mon_got.cap);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    n_bad++;
                    $display("FAIL event: got cyc=%0d kind=%b sel=%0d piece=%h cap=%h, required cyc=%0d kind=%b sel=%0d piece=%h cap=%h",
                             mon_got.cyc, mon_got.kind, mon_got.sel, mon_got.piece, mon_got.cap,
                             mon_exp.cyc, mon_exp.kind, mon_exp.sel, mon_exp.piece, mon_exp.cap);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic push_ev(input int c, input logic [3:0] k, input logic [5:0] s,
                           input logic [5:0] p, input logic [5:0] cp);
        ev_t e;
        e.cyc = c; e.kind = k; e.sel = s; e.piece = p; e.cap = cp;
        exp_q.push_back(e);
    endtask

    task automatic expect_move(input int a, input logic [5:0] org, input logic [5:0] dst,
                               input logic [5:0] pc, input logic [5:0] cp);
        push_ev(a,     K_CLR,  org, 6'h0, 6'h0);
        push_ev(a + 1, K_LD,   dst, pc,   6'h0);
        push_ev(a + 2, K_DONE, 6'h0, 6'h0, cp);
    endtask

    // Returns the cycle number in which the first post-accept cycle is observed.
    task automatic send(input logic [31:0] w, output int a);
        int t = 0;
        @(negedge clk);
        while (!move_in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!move_in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: got ready=0 after %0d cycles, required ready=1", t);
            a = -100;
        end else begin
            move_in = w;
            move_in_valid = 1'b1;
            @(posedge clk);
            #1;
            move_in_valid = 1'b0;
            move_in = '0;
            a = cyc;
        end
    endtask

    task automatic unmake(output int u);
        unmake_req = 1'b1;
        @(posedge clk);
        #1;
        unmake_req = 1'b0;
        u = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a, b, u;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {move_in_ready, board_enable, board_clear, move_done, err,
                              board_sel, board_piece, captured_piece, stack_count}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_idle", move_in_ready, 1);

        send(W1, a);
        expect_move(a, 6'd8, 6'd21, 6'h02, 6'h28);
        repeat (3) @(negedge clk);
        chk("ready_low_in_done", move_in_ready, 0);
        @(negedge clk);
        chk("ready_back_n4", move_in_ready, 1);
        chk("captured_held", captured_piece, 6'h28);

        send(W2, a);
        expect_move(a, 6'd1, 6'd63, 6'h22, 6'h00);

        send(32'h0010_3E00, a);
        expect_move(a, 6'd0, 6'd16, 6'h2F, 6'h00);

        send(32'h0000_0000, a);
        send(32'h4000_0000, b);
        push_ev(b, K_ERR, 6'h0, 6'h0, 6'h0);
        send(32'h0005_0005, b);
        push_ev(b, K_ERR, 6'h0, 6'h0, 6'h0);
        repeat (3) @(negedge clk);
        chk("captured_after_drops", captured_piece, 6'h00);

`ifdef MOVE_UNDO_EN
        send(W1, a);
        expect_move(a, 6'd8, 6'd21, 6'h02, 6'h28);
        repeat (4) @(negedge clk);
        chk("stack_after_push", stack_count, 1);
        unmake(u);
        push_ev(u,     K_LD,   6'd8,  6'h02, 6'h0);
        push_ev(u + 1, K_LD,   6'd21, 6'h28, 6'h0);
        push_ev(u + 2, K_DONE, 6'h0,  6'h0,  6'h0);
        chk("stack_after_pop", stack_count, 0);
        repeat (4) @(negedge clk);
        unmake(u);
        push_ev(u, K_ERR, 6'h0, 6'h0, 6'h0);
        chk("stack_empty_pop", stack_count, 0);

        for (int i = 0; i < 16; i++) begin
            send((32'(i + 16) << 16) | 32'(i), a);
            expect_move(a, 6'(i), 6'(i + 16), 6'h00, 6'h00);
        end
        repeat (4) @(negedge clk);
        chk("stack_full_count", stack_count, 16);
        chk("ready_low_full", move_in_ready, 0);
        move_in = W1;
        move_in_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("ready_still_low", move_in_ready, 0);
        unmake(u);
        push_ev(u,     K_LD,   6'd15, 6'h00, 6'h0);
        push_ev(u + 1, K_CLR,  6'd31, 6'h00, 6'h0);
        push_ev(u + 2, K_DONE, 6'h0,  6'h0,  6'h0);
        repeat (4) @(negedge clk);
        chk("ready_reopened", move_in_ready, 1);
        @(posedge clk);
        #1;
        move_in_valid = 1'b0;
        move_in = '0;
        a = cyc;
        expect_move(a, 6'd8, 6'd21, 6'h02, 6'h28);
        repeat (4) @(negedge clk);
        chk("stack_refilled", stack_count, 16);
`else
        unmake_req = 1'b1;
        send(W1, a);
        expect_move(a, 6'd8, 6'd21, 6'h02, 6'h28);
        unmake_req = 1'b0;
        repeat (4) @(negedge clk);
        chk("stack_count_off", stack_count, 0);
`endif

        send(W1, a);
        push_ev(a, K_CLR, 6'd8, 6'h0, 6'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("reset_mid_move", {move_in_ready, board_enable, board_clear, move_done, err,
                               board_sel, board_piece, captured_piece, stack_count}, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        send(W2, a);
        expect_move(a, 6'd1, 6'd63, 6'h22, 6'h00);

        repeat (6) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
